// File: rtl/axioma_eeprom_array.sv
// axioma_eeprom_array: 1 KB EEPROM cell array with timed read, erase and program phases.
module axioma_eeprom_array #(
  parameter int         DEPTH        = 1024,
  parameter int         ADDR_W       = 10,
  parameter int         READ_CYCLES  = 4,
  parameter int         ERASE_CYCLES = 3400,
  parameter int         PROG_CYCLES  = 3400,
  parameter logic [7:0] INIT_VALUE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [2:0]        debug_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, ERASE = 3'd2, PROG = 3'd3, DONE = 3'd4} state_t;
  localparam logic [1:0] OP_EW = 2'b00, OP_WR = 2'b10, OP_RD = 2'b11;
  localparam int MAXC = READ_CYCLES > ERASE_CYCLES ?
                        (READ_CYCLES > PROG_CYCLES ? READ_CYCLES : PROG_CYCLES) :
                        (ERASE_CYCLES > PROG_CYCLES ? ERASE_CYCLES : PROG_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] READ_LD  = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] ERASE_LD = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] PROG_LD  = CW'(PROG_CYCLES - 1);
  logic [7:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic last, in_range, mem_we;
  logic [7:0] mem_wd;
  // Power-on content only; reset never touches the cells.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = INIT_VALUE;
  assign last     = cnt_q == '0;
  assign in_range = 32'(req_addr) < 32'(DEPTH);
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_wd      = 8'hFF;
    cnt_d       = (state_q inside {READ, ERASE, PROG}) && !last ? cnt_q - CW'(1) : cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (!in_range) begin
          state_d     = DONE;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = req_op == OP_RD ? READ : req_op == OP_WR ? PROG : ERASE;
          cnt_d   = req_op == OP_RD ? READ_LD : req_op == OP_WR ? PROG_LD : ERASE_LD;
        end
      end
      READ: if (last) begin
        state_d     = DONE;
        rsp_rdata_d = mem[addr_q];
        rsp_err_d   = 1'b0;
      end
      ERASE: if (last) begin
        mem_we = 1'b1;
        cnt_d  = PROG_LD;
        if (op_q == OP_EW) state_d = PROG;
        else begin
          state_d     = DONE;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b0;
        end
      end
      PROG: if (last) begin
        mem_we      = 1'b1;
        mem_wd      = op_q == OP_EW ? wdata_q : mem[addr_q] & wdata_q;
        state_d     = DONE;
        rsp_rdata_d = 8'h00;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  // Commits happen only on a phase's final edge, so an aborted phase leaves the cell intact.
  always @(posedge clk) if (mem_we) mem[addr_q] <= mem_wd;
  assign req_ready   = state_q == IDLE;
  assign busy        = !req_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign debug_state = state_q;
endmodule

// File: tb/tb_axioma_eeprom_array.sv
// tb_axioma_eeprom_array: scoreboard bench with a per-cell reference array and randomized traffic.
module tb_axioma_eeprom_array;
  localparam int DEPTH = 1000, RC = 4, EC = 8, PC = 8;
  logic clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0;
  logic [1:0] req_op = '0;
  logic [9:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic [2:0] debug_state;

  axioma_eeprom_array #(
    .DEPTH(DEPTH), .ADDR_W(10), .READ_CYCLES(RC), .ERASE_CYCLES(EC),
    .PROG_CYCLES(PC), .INIT_VALUE(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    bit         rd_chk;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic [7:0] model [1024];
  int cyc = 0;
  int checks = 0, errors = 0;
  int acc_last = -10, end_last = -10;
  bit chk_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Drives one request until accepted; the expected response is derived from the cell model.
  task automatic do_req(input logic [1:0] op, input int a, input logic [7:0] d,
                        input bit push, output int acc);
    exp_t e;
    int lat;
    req_op = op; req_addr = a[9:0]; req_wdata = d; req_valid = 1'b1; acc = -1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        lat = 0;
        e.rd = 8'h00; e.err = 1'b0; e.rd_chk = 1'b0;
        if (push) begin
          if (a >= DEPTH) begin
            e.err = 1'b1; e.rd_chk = 1'b1;
          end else begin
            case (op)
              2'b11: begin lat = RC; e.rd = model[a]; e.rd_chk = 1'b1; end
              2'b01: begin lat = EC; model[a] = 8'hFF; end
              2'b10: begin lat = PC; model[a] = model[a] & d; end
              default: begin lat = EC + PC; model[a] = d; end
            endcase
          end
          e.acc = acc; e.lat = lat;
          sb.push_back(e);
          acc_last = acc; end_last = acc + lat;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL accept_timeout: request op %0d addr %0h never accepted", op, a);
    req_valid = 1'b0;
  endtask

  // Starts an erase+write and pulls reset partway through it.
  task automatic abort_ew(input int a, input logic [7:0] d, input int wait_n, input bit in_prog);
    int acc;
    chk_ready = 1'b0;
    do_req(2'b00, a, d, 1'b0, acc);
    repeat (wait_n) @(negedge clk);
    chk("abort_phase", debug_state, in_prog ? 3 : 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_idle", debug_state, 0);
    chk("abort_ready", req_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);
    if (in_prog) model[a] = 8'hFF;
    chk_ready = 1'b1;
  endtask

  always @(negedge clk) if (reset_n) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding at cycle %0d", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("rsp_err", rsp_err, m_e.err);
        chk("rsp_latency", cyc - m_e.acc, m_e.lat);
        if (m_e.rd_chk) chk("rsp_rdata", rsp_rdata, m_e.rd);
      end
    end
    if (chk_ready) chk("req_ready", req_ready, !(cyc >= acc_last && cyc <= end_last));
    chk("busy_inv", busy, !req_ready);
  end

  initial begin
    int acc, acc1, acc2, a, op;
    for (int i = 0; i < 1024; i++) model[i] = 8'hFF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_state", debug_state, 0);
    chk_ready = 1'b1;

    do_req(2'b11, 0, 8'h00, 1'b1, acc);
    chk("read_state", debug_state, 1);

    do_req(2'b00, 'h3A5, 8'h5C, 1'b1, acc);
    do_req(2'b11, 'h3A5, 8'h00, 1'b1, acc);
    do_req(2'b11, 'h3A4, 8'h00, 1'b1, acc);
    do_req(2'b11, 'h3A6, 8'h00, 1'b1, acc);

    do_req(2'b10, 'h3A5, 8'hF0, 1'b1, acc);
    do_req(2'b11, 'h3A5, 8'h00, 1'b1, acc);
    do_req(2'b01, 'h3A5, 8'h00, 1'b1, acc);
    do_req(2'b11, 'h3A5, 8'h00, 1'b1, acc);

    do_req(2'b00, 'h100, 8'hA7, 1'b1, acc1);
    do_req(2'b11, 0, 8'h00, 1'b1, acc2);
    chk("hold_accept", acc2, acc1 + EC + PC + 2);
    do_req(2'b11, 'h100, 8'h00, 1'b1, acc);

    do_req(2'b00, 'h010, 8'h33, 1'b1, acc);
    abort_ew('h010, 8'h77, 3, 1'b0);
    do_req(2'b11, 'h010, 8'h00, 1'b1, acc);
    abort_ew('h010, 8'h77, 9, 1'b1);
    do_req(2'b11, 'h010, 8'h00, 1'b1, acc);

    do_req(2'b00, 1000, 8'h12, 1'b1, acc);
    do_req(2'b11, 0, 8'h00, 1'b1, acc);
    do_req(2'b11, 999, 8'h00, 1'b1, acc);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 995 + int'($urandom_range(0, 28)) : int'($urandom_range(0, 15));
      do_req(op[1:0], a, 8'($urandom), 1'b1, acc);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
